// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
// The master drives the synchronous controls. The slave (the counter) returns the registered count and flags.
interface mod_updown_counter_if #(
  parameter int WIDTH = 32
);
  // Level-sampled controls with no valid/ready handshake. The counter samples
  // clear/load/enable/up_down/load_value on every rising clock edge and acts on
  // them in the priority clear > load > enable > hold. count, tc_pulse and
  // overflow are registered and reflect the controls one edge later.
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             up_down;
  logic [WIDTH-1:0] count;
  logic             tc_pulse;
  logic             overflow;

  modport master (
    output clear, load, load_value, enable, up_down,
    input  count, tc_pulse, overflow
  );

  modport slave (
    input  clear, load, load_value, enable, up_down,
    output count, tc_pulse, overflow
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter (0..MAX_VAL) with clear, clamped load, terminal-count pulse and sticky overflow.
// Define COUNTER_SATURATE_EN to make the counter hold at the range ends instead of wrapping.
module mod_updown_counter #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input logic                  clock,
  input logic                  reset,
  mod_updown_counter_if.slave  bus
);

`ifdef COUNTER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;

  assign at_max       = (count_q == MAX_VAL);
  assign at_zero      = (count_q == '0);
  assign load_clamped = (bus.load_value > MAX_VAL) ? MAX_VAL : bus.load_value;

  // Range checks happen on the current count, so the stepped value never leaves 0..MAX_VAL.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (bus.load) begin
      count_d = load_clamped;
    end else if (bus.enable) begin
      if (bus.up_down) begin
        if (at_max) begin
          count_d = SATURATE ? MAX_VAL : '0;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (at_zero) begin
          count_d = SATURATE ? '0 : MAX_VAL;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.tc_pulse = tc_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed vector bench for mod_updown_counter (WIDTH=4, MAX_VAL=9), plus a MAX_VAL=1 instance.
// Expected values follow the wrap or the saturate behaviour depending on COUNTER_SATURATE_EN.
module tb_mod_updown_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Count shown after a boundary step going up / going down.
  localparam logic [3:0] UPW = SAT ? 4'd9 : 4'd0;
  localparam logic [3:0] DNW = SAT ? 4'd0 : 4'd9;

  typedef struct {
    string      name;
    logic       clear;
    logic       load;
    logic [3:0] load_value;
    logic       enable;
    logic       up_down;
    logic [3:0] exp_count;
    logic       exp_tc;
    logic       exp_ovf;
  } vec_t;

  logic clock;
  logic reset;
  int   vec_count;
  int   miss_count;
  vec_t vecs[$];

  mod_updown_counter_if #(.WIDTH(4)) bus_a ();
  mod_updown_counter_if #(.WIDTH(2)) bus_b ();

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  mod_updown_counter #(.WIDTH(2), .MAX_VAL(2'd1)) dut_m1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_a(input string name, input logic [3:0] c, input logic t, input logic o);
    check({name, ".count"},    32'(bus_a.count),    32'(c));
    check({name, ".tc_pulse"}, 32'(bus_a.tc_pulse), 32'(t));
    check({name, ".overflow"}, 32'(bus_a.overflow), 32'(o));
  endtask

  // driver
  task automatic drive_a(input logic c, input logic l, input logic [3:0] lv, input logic e, input logic ud);
    bus_a.clear      = c;
    bus_a.load       = l;
    bus_a.load_value = lv;
    bus_a.enable     = e;
    bus_a.up_down    = ud;
  endtask

  task automatic step_a(input string name, input logic c, input logic l, input logic [3:0] lv,
                        input logic e, input logic ud,
                        input logic [3:0] xc, input logic xt, input logic xo);
    drive_a(c, l, lv, e, ud);
    @(posedge clock);
    #1;
    check_a(name, xc, xt, xo);
  endtask

  task automatic add(input string n, input logic c, input logic l, input logic [3:0] lv,
                     input logic e, input logic ud,
                     input logic [3:0] xc, input logic xt, input logic xo);
    vec_t v;
    v.name = n; v.clear = c; v.load = l; v.load_value = lv; v.enable = e; v.up_down = ud;
    v.exp_count = xc; v.exp_tc = xt; v.exp_ovf = xo;
    vecs.push_back(v);
  endtask

  initial begin
    logic [1:0] m1_exp_count [4];
    logic       m1_exp_tc    [4];

    vec_count  = 0;
    miss_count = 0;

    // name, clear, load, load_value, enable, up_down -> count, tc, overflow
    for (int i = 1; i <= 9; i++) add("up_count", 0, 0, 4'd0, 1, 1, 4'(i), 0, 0);
    add("up_wrap",        0, 0, 4'd0,  1, 1, UPW,  1, 1);
    add("hold_after_wrap",0, 0, 4'd0,  0, 1, UPW,  0, 1);
    add("load_2",         0, 1, 4'd2,  0, 0, 4'd2, 0, 1);
    add("down_1",         0, 0, 4'd0,  1, 0, 4'd1, 0, 1);
    add("down_0",         0, 0, 4'd0,  1, 0, 4'd0, 0, 1);
    add("down_wrap",      0, 0, 4'd0,  1, 0, DNW,  1, 1);
    add("load_beats_en",  0, 1, 4'd5,  1, 1, 4'd5, 0, 1);
    add("clear_beats_all",1, 1, 4'd5,  1, 1, 4'd0, 0, 0);
    add("load_clamp",     0, 1, 4'd14, 0, 1, 4'd9, 0, 0);
    add("clamp_then_up",  0, 0, 4'd0,  1, 1, UPW,  1, 1);
    add("clear",          1, 0, 4'd0,  0, 0, 4'd0, 0, 0);
    add("down_from_0",    0, 0, 4'd0,  1, 0, DNW,  1, 1);
    add("load_3",         0, 1, 4'd3,  0, 1, 4'd3, 0, 1);
    add("dir_up",         0, 0, 4'd0,  1, 1, 4'd4, 0, 1);
    add("dir_down",       0, 0, 4'd0,  1, 0, 4'd3, 0, 1);
    add("dir_up_again",   0, 0, 4'd0,  1, 1, 4'd4, 0, 1);
    add("hold",           0, 0, 4'd0,  0, 0, 4'd4, 0, 1);
    add("load_max",       0, 1, 4'd9,  0, 1, 4'd9, 0, 1);
    add("max_up",         0, 0, 4'd0,  1, 1, UPW,  1, 1);
    add("tc_drops",       0, 0, 4'd0,  0, 1, UPW,  0, 1);

    drive_a(0, 0, 4'd0, 0, 0);
    bus_b.clear = 1'b0; bus_b.load = 1'b0; bus_b.load_value = 2'd0;
    bus_b.enable = 1'b0; bus_b.up_down = 1'b0;
    reset = 1'b0;
    #1;
    check_a("reset_state", 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step_a(vecs[i].name, vecs[i].clear, vecs[i].load, vecs[i].load_value,
             vecs[i].enable, vecs[i].up_down,
             vecs[i].exp_count, vecs[i].exp_tc, vecs[i].exp_ovf);
    end

`ifdef COUNTER_SATURATE_EN
    step_a("sat_load_9", 0, 1, 4'd9, 0, 1, 4'd9, 0, 1);
    for (int i = 0; i < 3; i++) step_a("sat_up_hold", 0, 0, 4'd0, 1, 1, 4'd9, 1, 1);
    step_a("sat_load_0", 0, 1, 4'd0, 0, 0, 4'd0, 0, 1);
    for (int i = 0; i < 2; i++) step_a("sat_down_hold", 0, 0, 4'd0, 1, 0, 4'd0, 1, 1);
`endif

    // Asynchronous reset in the middle of a cycle, with the count at 7 and overflow set.
    step_a("load_7", 0, 1, 4'd7, 0, 1, 4'd7, 0, 1);
    drive_a(0, 0, 4'd0, 1, 1);
    #2;
    reset = 1'b0;
    #1;
    check_a("async_reset", 4'd0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check_a("reset_held", 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_a("first_after_reset", 4'd1, 1'b0, 1'b0);
    drive_a(0, 0, 4'd0, 0, 0);

    // MAX_VAL=1 with continuous enable: toggling count, tc every other cycle.
    m1_exp_count[0] = 2'd1;            m1_exp_tc[0] = 1'b0;
    m1_exp_count[1] = SAT ? 2'd1 : 2'd0; m1_exp_tc[1] = 1'b1;
    m1_exp_count[2] = 2'd1;            m1_exp_tc[2] = SAT;
    m1_exp_count[3] = SAT ? 2'd1 : 2'd0; m1_exp_tc[3] = 1'b1;
    bus_b.enable  = 1'b1;
    bus_b.up_down = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      check("m1.count",    32'(bus_b.count),    32'(m1_exp_count[i]));
      check("m1.tc_pulse", 32'(bus_b.tc_pulse), 32'(m1_exp_tc[i]));
      check("m1.overflow", 32'(bus_b.overflow), (i == 0) ? 32'd0 : 32'd1);
    end
    bus_b.enable = 1'b0;

    // report
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
